// File: rtl/div_pkg.sv
// div_pkg: shared width default and FSM state encoding for the sequential divider.
package div_pkg;
  localparam int WIDTH = 8;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division trial subtract and select.
import div_pkg::*;
module div_restore_step #(
  parameter int W = WIDTH
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] div_i,
  output logic [W:0]   rem_o,
  output logic         q_bit_o
);
  logic [W+1:0] c;
  logic [W:0]   diff;
  logic [W:0]   div_n;
  // a - b as a + ~b + 1; a final carry out means no borrow, so trial >= 0
  assign div_n = ~{1'b0, div_i};
  assign c[0] = 1'b1;
  genvar i;
  for (i = 0; i <= W; i++) begin : g_fa
    one_bit_full_adder u_fa (
      .a_i(rem_i[i]),
      .b_i(div_n[i]),
      .c_i(c[i]),
      .s_o(diff[i]),
      .c_o(c[i+1])
    );
  end
  assign q_bit_o = c[W+1];
  assign rem_o = q_bit_o ? diff : rem_i;
endmodule

// File: rtl/one_bit_full_adder.sv
// one_bit_full_adder: single-bit full adder cell.
module one_bit_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/eight_bit_seq_divider.sv
// eight_bit_seq_divider: unsigned restoring divider, one quotient bit per cycle.
import div_pkg::*;
module eight_bit_seq_divider #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d, step_rem;
  logic [WIDTH-1:0] quo_q, quo_d, div_q, div_d, rem_q, rem_d;
  logic             dbz_q, dbz_d, q_bit;
  div_restore_step #(.W(WIDTH)) u_step (
    .rem_i({prem_q[WIDTH-1:0], quo_q[WIDTH-1]}),
    .div_i(div_q),
    .rem_o(step_rem),
    .q_bit_o(q_bit)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (in_valid) begin
        div_d   = divisor;
        dbz_d   = divisor == '0;
        quo_d   = dbz_d ? '1 : dividend;
        rem_d   = dividend;
        prem_d  = '0;
        cnt_d   = '0;
        state_d = dbz_d ? DONE : RUN;
      end
      RUN: begin
        prem_d  = step_rem;
        quo_d   = {quo_q[WIDTH-2:0], q_bit};
        cnt_d   = cnt_q + 1'b1;
        rem_d   = cnt_q == CW'(WIDTH - 1) ? step_rem[WIDTH-1:0] : rem_q;
        state_d = cnt_q == CW'(WIDTH - 1) ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end
  assign in_ready    = rst_n && state_q == IDLE;
  assign out_valid   = rst_n && state_q == DONE;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
